// File: rtl/toeplitz_pkg.sv
// Shared types, default sizes and helpers for the Toeplitz seed path.
package toeplitz_pkg;

  localparam int unsigned DEF_BS = 64;
  localparam int unsigned DEF_N  = 256;
  localparam int unsigned DEF_L  = 128;
  localparam int unsigned DEF_GW = 8;

  typedef enum logic [1:0] {
    S_ROW    = 2'd0,
    S_COL    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Bit reversal of a default-width row; the hashing core uses the same helper.
  function automatic logic [DEF_N-1:0] bitrev(input logic [DEF_N-1:0] v);
    logic [DEF_N-1:0] r;
    for (int i = 0; i < int'(DEF_N); i++) r[i] = v[int'(DEF_N)-1-i];
    return r;
  endfunction

endpackage

// File: rtl/toeplitz_seed_loader_shadow.sv
// Shadow row/column registers written by word index, copied to the active set on commit.
module seed_shadow_regs #(
  parameter int unsigned BS = 64,
  parameter int unsigned N  = 256,
  parameter int unsigned L  = 128,
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_idx,
  input  logic [BS-1:0] wr_data,
  input  logic          commit,
  output logic [N-1:0]  row0,
  output logic [N-1:0]  rrow0,
  output logic [L-1:0]  col0
);

  localparam int unsigned NWR = N / BS;
  localparam int unsigned NWC = L / BS;

  logic [N-1:0] shadow_row;
  logic [N-1:0] rev_row;
  logic [L-1:0] shadow_col;

  // Word index 0..NWR-1 lands in the row, NWR..NWR+NWC-1 in the column, word 0 at the LSBs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_row <= '0;
      shadow_col <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < int'(NWR); k++) begin
        if (wr_idx == CW'(k)) shadow_row[k*BS +: BS] <= wr_data;
      end
      for (int j = 0; j < int'(NWC); j++) begin
        if (wr_idx == CW'(int'(NWR) + j)) shadow_col[j*BS +: BS] <= wr_data;
      end
    end
  end

  // Reversed row is prepared from the shadow so the active copy is a plain register load.
  for (genvar i = 0; i < int'(N); i++) begin : g_rev
    assign rev_row[i] = shadow_row[int'(N)-1-i];
  end

  // Active registers change only on commit, all fields together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row0  <= '0;
      rrow0 <= '0;
      col0  <= '0;
    end else if (commit) begin
      row0  <= shadow_row;
      rrow0 <= rev_row;
      col0  <= shadow_col;
    end
  end

endmodule

// File: rtl/toeplitz_seed_loader.sv
// Streams a Toeplitz seed (row then column) and atomically commits well-framed seeds.
module toeplitz_seed_loader
  import toeplitz_pkg::*;
#(
  parameter int unsigned BS = DEF_BS,
  parameter int unsigned N  = DEF_N,
  parameter int unsigned L  = DEF_L,
  parameter int unsigned GW = DEF_GW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [BS-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          abort,
  output logic [N-1:0]  row0,
  output logic [N-1:0]  rrow0,
  output logic [L-1:0]  col0,
  output logic          seed_valid,
  output logic [GW-1:0] seed_gen,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned NWR = N / BS;
  localparam int unsigned NWC = L / BS;
  localparam int unsigned NW  = NWR + NWC;
  localparam int unsigned CW  = (NW > 1) ? $clog2(NW) : 1;

  if ((N % BS) != 0 || (L % BS) != 0) begin : g_bad_size
    $error("toeplitz_seed_loader: N and L must be multiples of BS");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en;
  logic          commit;
  logic          err_set;
  logic          last_word;

  assign last_word = (cnt_q == CW'(NW - 1));

  // Next state, word counter and framing check; abort outranks framing, framing outranks accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      S_ROW, S_COL: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_ROW;
        end else if (s_valid && s_ready) begin
          if (s_last != last_word) begin
            err_set = 1'b1;
            cnt_d   = '0;
            state_d = S_ROW;
          end else begin
            wr_en = 1'b1;
            if (last_word) begin
              cnt_d   = '0;
              state_d = S_COMMIT;
            end else begin
              cnt_d = cnt_q + CW'(1);
              if (cnt_q == CW'(NWR - 1)) state_d = S_COL;
            end
          end
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        cnt_d   = '0;
        state_d = S_ROW;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_ROW;
      end
    endcase
  end

  // State, ready, sticky error and commit bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_ROW;
      cnt_q      <= '0;
      s_ready    <= 1'b0;
      err        <= 1'b0;
      seed_valid <= 1'b0;
      seed_gen   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_ready <= (state_d != S_COMMIT);
      if (err_set) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (commit) begin
        seed_valid <= 1'b1;
        seed_gen   <= seed_gen + GW'(1);
      end
    end
  end

  seed_shadow_regs #(
    .BS (BS),
    .N  (N),
    .L  (L),
    .CW (CW)
  ) u_shadow (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q),
    .wr_data (s_data),
    .commit  (commit),
    .row0    (row0),
    .rrow0   (rrow0),
    .col0    (col0)
  );

endmodule

// File: tb/tb_toeplitz_seed_loader.sv
// Directed scoreboard bench for toeplitz_seed_loader (default sizes plus a GW=2 twin).
module tb_toeplitz_seed_loader;

  logic          clk;
  logic          reset_n;
  logic [63:0]   s_data;
  logic          s_valid;
  logic          s_last;
  logic          abort;
  logic          err_clr;

  logic          s_ready,    s_ready2;
  logic [255:0]  row0,       row0_2;
  logic [255:0]  rrow0,      rrow0_2;
  logic [127:0]  col0,       col0_2;
  logic          seed_valid, seed_valid2;
  logic [7:0]    seed_gen;
  logic [1:0]    seed_gen2;
  logic          err,        err2;

  typedef struct packed {
    logic [255:0] row;
    logic [127:0] col;
    logic [7:0]   gen;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   exp_gen = '0;
  logic [255:0] cur_row = '0;
  logic [63:0]  fw [6];

  toeplitz_seed_loader dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .abort(abort), .row0(row0), .rrow0(rrow0), .col0(col0),
    .seed_valid(seed_valid), .seed_gen(seed_gen), .err(err), .err_clr(err_clr)
  );

  toeplitz_seed_loader #(.GW(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready2), .abort(abort), .row0(row0_2), .rrow0(rrow0_2), .col0(col0_2),
    .seed_valid(seed_valid2), .seed_gen(seed_gen2), .err(err2), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] rev256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 256; i++) r[i] = v[255-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one word and wait (bounded) for it to be taken; returns #1 after the taking edge.
  task automatic send_word(input logic [63:0] d, input logic last, input logic hold);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Send fw[] as a well-framed seed and score the commit two edges after the last word.
  task automatic run_frame(input logic hold);
    exp_t e;
    e.row   = {fw[3], fw[2], fw[1], fw[0]};
    e.col   = {fw[5], fw[4]};
    exp_gen = exp_gen + 8'd1;
    e.gen   = exp_gen;
    sb.push_back(e);
    for (int k = 0; k < 6; k++) send_word(fw[k], (k == 5), hold);
    check("commit_ready_low", 256'(s_ready), 256'(0));
    check("row_held_until_commit", row0, cur_row);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("ready_back", 256'(s_ready), 256'(1));
    check("row0", row0, e.row);
    check("col0", 256'(col0), 256'(e.col));
    check("rrow0", rrow0, rev256(e.row));
    check("seed_valid", 256'(seed_valid), 256'(1));
    check("seed_gen", 256'(seed_gen), 256'(e.gen));
    check("seed_gen_gw2", 256'(seed_gen2), 256'(e.gen[1:0]));
    check("seed_valid_gw2", 256'(seed_valid2), 256'(1));
    cur_row = e.row;
  endtask

  initial begin
    reset_n = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    abort   = 1'b0;
    err_clr = 1'b0;
    #1;
    check("rst_row0", row0, 256'(0));
    check("rst_seed_valid", 256'(seed_valid), 256'(0));
    check("rst_ready", 256'(s_ready), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("ready_before_edge", 256'(s_ready), 256'(0));
    @(posedge clk);
    #1;
    check("ready_after_release", 256'(s_ready), 256'(1));

    // Nominal load, s_valid kept high into the next frame.
    fw = '{64'h1, 64'h2, 64'h3, 64'h4, 64'hA, 64'hB};
    run_frame(1'b1);
    check("rrow0_msb", 256'(rrow0[255]), 256'(1));
    check("row0_literal", row0, {64'h4, 64'h3, 64'h2, 64'h1});

    // Back-to-back all-ones frame.
    fw = '{6{64'hFFFF_FFFF_FFFF_FFFF}};
    run_frame(1'b0);

    // Early s_last on row word 2.
    send_word(64'h11, 1'b0, 1'b0);
    send_word(64'h22, 1'b0, 1'b0);
    send_word(64'h33, 1'b1, 1'b0);
    check("early_last_err", 256'(err), 256'(1));
    check("early_last_row_kept", row0, cur_row);
    check("early_last_gen_kept", 256'(seed_gen), 256'(exp_gen));
    check("early_last_ready", 256'(s_ready), 256'(1));

    fw = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50, 64'h60};
    run_frame(1'b0);
    check("err_sticky", 256'(err), 256'(1));

    // Missing s_last on the final word.
    for (int k = 0; k < 6; k++) send_word(64'hC0 + 64'(k), 1'b0, 1'b0);
    check("missing_last_gen_kept", 256'(seed_gen), 256'(exp_gen));
    check("missing_last_row_kept", row0, cur_row);

    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_cleared", 256'(err), 256'(0));

    // Abort after 3 words; the word presented with abort (s_last set) must be dropped silently.
    send_word(64'hDEAD_0001, 1'b0, 1'b0);
    send_word(64'hDEAD_0002, 1'b0, 1'b0);
    send_word(64'hDEAD_0003, 1'b0, 1'b0);
    s_data  = 64'hDEAD_0004;
    s_valid = 1'b1;
    s_last  = 1'b1;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("abort_no_err", 256'(err), 256'(0));
    check("abort_gen_kept", 256'(seed_gen), 256'(exp_gen));
    fw = '{6{64'hFFFF_0000_FFFF_0000}};
    run_frame(1'b0);

    // Fifth commit: GW=2 twin wraps 3 -> 0 -> 1 across these frames.
    fw = '{64'h5, 64'h6, 64'h7, 64'h8, 64'h9, 64'hC};
    run_frame(1'b0);

    // Asynchronous reset mid-column, with err set beforehand.
    send_word(64'h1, 1'b1, 1'b0);
    check("pre_reset_err", 256'(err), 256'(1));
    for (int k = 0; k < 5; k++) send_word(64'hE0 + 64'(k), 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("async_row0", row0, 256'(0));
    check("async_rrow0", rrow0, 256'(0));
    check("async_col0", 256'(col0), 256'(0));
    check("async_seed_valid", 256'(seed_valid), 256'(0));
    check("async_seed_gen", 256'(seed_gen), 256'(0));
    check("async_err", 256'(err), 256'(0));
    check("async_ready", 256'(s_ready), 256'(0));
    check("async_gen_gw2", 256'(seed_gen2), 256'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("ready_low_at_release", 256'(s_ready), 256'(0));
    @(posedge clk);
    #1;
    check("ready_one_edge_after", 256'(s_ready), 256'(1));
    exp_gen = '0;
    cur_row = '0;

    fw = '{64'h100, 64'h200, 64'h300, 64'h400, 64'h500, 64'h600};
    run_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toeplitz_seed_loader.md
Name: toeplitz_seed_loader

Overview:
- Streams a Toeplitz seed (first row, then first column) in BS-bit words and assembles it in shadow registers.
- Atomically commits a complete, well-framed seed to the active row0/rrow0/col0 outputs consumed by the hashing datapath.
- Successor to the static seed reader: run-time reloadable, double-buffered, framing-checked, with a generation counter.

Parameters:
- BS, 64, stream word width in bits.
- N, 256, row length in bits; must be a multiple of BS.
- L, 128, column length in bits; must be a multiple of BS.
- GW, 8, width of the seed generation counter.

Ports:
- clk  input  1  clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- s_data  input  BS  seed word.
- s_valid  input  1  s_data valid.
- s_last  input  1  marks the final word of a seed frame.
- s_ready  output  1  loader accepts a word this cycle.
- abort  input  1  discard the partially loaded frame.
- row0  output  N  active first row.
- rrow0  output  N  bit-reversed active row: rrow0[i] = row0[N-1-i].
- col0  output  L  active first column.
- seed_valid  output  1  at least one seed committed since reset.
- seed_gen  output  GW  commit count, wraps modulo 2^GW.
- err  output  1  sticky framing error.
- err_clr  input  1  clears err.

Behaviour:
- Constants: NWR = N/BS, NWC = L/BS, NW = NWR+NWC; word counter width is $clog2(NW).
- Reset (asynchronous, reset_n=0):
  - row0, rrow0, col0, shadow registers, counter, seed_gen = 0.
  - seed_valid = 0, err = 0, s_ready = 0, FSM = S_ROW.
  - s_ready goes to 1 in the first clock after reset_n deasserts.
- Word transfer: a word is taken on a clock edge with s_valid && s_ready.
- FSM S_ROW (s_ready=1):
  - Word k (k=0..NWR-1) is written to shadow_row[k*BS +: BS], word 0 at the LSBs.
  - After word NWR-1, go to S_COL.
- FSM S_COL (s_ready=1):
  - Word j (j=0..NWC-1) is written to shadow_col[j*BS +: BS].
  - After word NWC-1, go to S_COMMIT.
- FSM S_COMMIT (s_ready=0, exactly one cycle):
  - row0 <= shadow_row; rrow0 <= reverse(shadow_row); col0 <= shadow_col.
  - seed_valid <= 1; seed_gen <= seed_gen + 1.
  - Counter cleared; return to S_ROW.
  - New outputs are visible the cycle after S_COMMIT. Latency from the last accepted word to updated outputs is 2 edges.
- Active outputs change only in S_COMMIT; they are never partially updated.
- Framing:
  - s_last must be 1 on word NW-1 and 0 on every other word.
  - On violation (early s_last, or missing s_last on word NW-1): the accepted word is dropped, err <= 1, counter cleared, FSM -> S_ROW, no commit. Active outputs, seed_gen and seed_valid are unchanged.
- abort: in S_ROW or S_COL, counter cleared and FSM -> S_ROW; a word presented in the same cycle is dropped. abort is ignored in S_COMMIT; the commit completes.
- Priority in one cycle: reset > abort > framing error > normal accept.
- err_clr: clears err. If a new error occurs in the same cycle, err stays 1.
- seed_gen wraps from 2^GW-1 to 0; seed_valid stays 1.
- s_valid with s_ready=0 is held by the source; there is no loss and no stall counting.

Decomposition:
- Package toeplitz_pkg holds:
  - The state enum (S_ROW, S_COL, S_COMMIT).
  - Default BS/N/L.
  - A function bitrev(N-bit) shared with the hashing core.
- One sub-module, seed_shadow_regs: parametrised shadow row/column write-by-index, with a commit-copy port for the active registers.
- The FSM, counter and framing checks stay in the top module.
- Elaboration-time assert: N%BS==0, L%BS==0.

Test Plan:
- Nominal load (BS=64, N=256, L=128):
  - Stimulus: row words 64'h1, 64'h2, 64'h3, 64'h4, then col words 64'hA, 64'hB (s_last on hB).
  - Required: row0 = {64'h4,64'h3,64'h2,64'h1}; col0 = {64'hB,64'hA}; rrow0[255]=1, rrow0[254:0]... consistent with bitrev; seed_valid=1, seed_gen=1; s_ready=0 for exactly one cycle.
- Back-to-back frames with s_valid held high:
  - Stimulus: second frame of all-ones words.
  - Required: row0 = all ones, seed_gen=2; outputs hold frame 1 until the commit edge.
- Early s_last on row word 2:
  - Required: err=1, outputs and seed_gen unchanged.
  - Then a full valid frame commits (seed_gen increments); err stays 1 until a err_clr pulse.
- Abort after 3 words, then a full frame of 64'hFFFF_0000_FFFF_0000:
  - Required: only the new frame is committed; no mixing of pre-abort words.
- Asynchronous reset asserted mid-column:
  - Required: all outputs 0 immediately (no clock edge needed); s_ready=0, then 1 one edge after release.
- GW=2 with 5 commits:
  - Required: seed_gen sequence 1, 2, 3, 0, 1; seed_valid stays 1.
